dmem_arbiter: RTL

- Shares the single-port data memory (including its LED/digit MMIO window) between the pipeline MEM stage and an external debug/loader master, e.g. a UART program loader.
- Sits between the EX/MEM register outputs and the data memory.
- Raises a stall to the pipeline hazard logic whenever the CPU is denied the memory.
- Provides a bounded-latency service guarantee for the debug port, and an exclusive lock mode for bulk loading.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage and a
// debug/loader master. The debug side gets bounded latency via a starvation
// counter, and can take exclusive ownership via a lock mode.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  // CPU (MEM stage) port
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  // Debug / loader port
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_dbg_ack,
  input  logic          i_lock_req,
  output logic          o_lock_ack,
  // Data memory port
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_read,
  output logic          o_mem_write,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StDack,
    StLock,
    StLack
  } state_t;

  localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_starve_cnt;
  logic [3:0]    w_starve_nxt;
  logic          r_dbg_ack;
  logic [DW-1:0] r_dbg_rdata;
  logic          r_lock_ack;

  logic          w_gnt_cpu;
  logic          w_gnt_dbg;
  logic          w_locked;

  assign w_locked = (r_state == StLock) || (r_state == StLack);

  // Grant decision; nothing is granted while reset is asserted
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_dbg = 1'b0;
    if (i_reset) begin
      case (r_state)
        StIdle: begin
          // A pending lock request pre-empts a debug grant this cycle
          if (i_dbg_req && !i_lock_req && (!i_cpu_req || (r_starve_cnt == LimitCnt))) begin
            w_gnt_dbg = 1'b1;
          end else begin
            w_gnt_cpu = i_cpu_req;
          end
        end
        StDack:  w_gnt_cpu = i_cpu_req;
        StLock:  w_gnt_dbg = i_dbg_req && i_lock_req;
        default: ;
      endcase
    end
  end

  // Memory port mux and CPU-side outputs
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    if (w_gnt_dbg) begin
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_wdata;
      o_mem_read  = !i_dbg_we;
      o_mem_write = i_dbg_we;
    end else if (w_gnt_cpu) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mem_read  = !i_cpu_we;
      o_mem_write = i_cpu_we;
    end
  end

  assign o_cpu_rdata = i_mem_rdata;
  assign o_cpu_stall = i_reset &&
                       (w_locked || ((r_state == StIdle) && i_cpu_req && w_gnt_dbg));
  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_lock_ack  = r_lock_ack;

  // Next-state and starvation counter update
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      StIdle: begin
        if (i_lock_req) begin
          w_state_nxt = StLock;
        end else if (w_gnt_dbg) begin
          w_state_nxt = StDack;
        end
        if (w_gnt_dbg || !i_dbg_req) begin
          w_starve_nxt = '0;
        end else if (w_gnt_cpu && (r_starve_cnt != LimitCnt)) begin
          w_starve_nxt = r_starve_cnt + 4'd1;
        end
      end
      StDack: w_state_nxt = i_lock_req ? StLock : StIdle;
      StLock: begin
        if (!i_lock_req) begin
          w_state_nxt = StIdle;
        end else if (w_gnt_dbg) begin
          w_state_nxt = StLack;
        end
      end
      StLack: w_state_nxt = i_lock_req ? StLock : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, counter and debug handshake registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_starve_cnt <= '0;
      r_dbg_ack    <= 1'b0;
      r_dbg_rdata  <= '0;
      r_lock_ack   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_dbg_ack    <= w_gnt_dbg;
      r_lock_ack   <= w_locked;
      if (w_gnt_dbg && !i_dbg_we) begin
        r_dbg_rdata <= i_mem_rdata;
      end
    end
  end

endmodule
